bcd4_down_timer: RTL and testbench



---
 rtl/bcd4_down_timer_pkg.sv | 22 ++
 rtl/bcd4_down_timer_if.sv | 28 ++
 rtl/bcd4_down_timer_bcd_digit_down.sv | 34 +++
 rtl/bcd4_down_timer.sv | 138 +++++++++++++
 tb/tb_bcd4_down_timer.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/bcd4_down_timer_pkg.sv
// bcd4_down_timer_pkg: shared state type, BCD constants and the preset clamp helper.
`default_nettype none

package bcd4_down_timer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSE   = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  localparam logic [3:0] BCD_MAX    = 4'd9;
  localparam int         NUM_DIGITS = 4;

  function automatic logic [3:0] clamp_bcd(input logic [3:0] nib);
    return (nib > BCD_MAX) ? BCD_MAX : nib;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bcd4_down_timer_if.sv
// bcd4_down_timer_if: control inputs and BCD digit/status outputs of the countdown timer.
`default_nettype none

interface bcd4_down_timer_if;
  logic        load;
  logic [15:0] preset;
  logic        start;
  logic        stop;
  logic [3:0]  digit0;
  logic [3:0]  digit1;
  logic [3:0]  digit2;
  logic [3:0]  digit3;
  logic        running;
  logic        zero;
  logic        done;

  modport master (
    output load, preset, start, stop,
    input  digit0, digit1, digit2, digit3, running, zero, done
  );

  modport slave (
    input  load, preset, start, stop,
    output digit0, digit1, digit2, digit3, running, zero, done
  );
endinterface

`default_nettype wire

// File: rtl/bcd4_down_timer_bcd_digit_down.sv
// bcd_digit_down: one BCD digit register that decrements when borrowed from, wrapping 0 to 9.
`default_nettype none

module bcd_digit_down (
  input  wire logic       clock,
  input  wire logic       reset,
  input  wire logic       i_load,
  input  wire logic [3:0] i_load_val,
  input  wire logic       i_dec_en,
  input  wire logic       i_borrow_in,
  output logic      [3:0] o_digit,
  output logic            o_borrow_out
);
  import bcd4_down_timer_pkg::*;

  logic [3:0] r_digit;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_digit <= 4'd0;
    end else if (i_load) begin
      r_digit <= i_load_val;
    end else if (i_dec_en && i_borrow_in) begin
      r_digit <= (r_digit == 4'd0) ? BCD_MAX : r_digit - 4'd1;
    end
  end

  // Borrow ripples combinationally so all digits settle on the same edge.
  assign o_borrow_out = i_borrow_in && (r_digit == 4'd0);
  assign o_digit      = r_digit;

endmodule

`default_nettype wire

// File: rtl/bcd4_down_timer.sv
// bcd4_down_timer: four-digit BCD countdown with start/stop control, expiry pulse and optional auto-reload.
`default_nettype none

module bcd4_down_timer #(
  parameter int TICK_DIV    = 1,
  parameter bit AUTO_RELOAD = 1'b0
) (
  input wire logic          clock,
  input wire logic          reset,
  bcd4_down_timer_if.slave  bus
);
  import bcd4_down_timer_pkg::*;

  localparam int             PW          = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]  c_TICK_LAST = PW'(TICK_DIV - 1);

  state_t          r_state;
  state_t          w_state_next;
  logic [PW-1:0]   r_presc;
  logic [PW-1:0]   w_presc_next;
  logic [15:0]     r_store;
  logic            r_done;
  logic            w_done_next;
  logic [15:0]     w_preset_clamped;
  logic [15:0]     w_count;
  logic [15:0]     w_load_val;
  logic            w_load_digits;
  logic            w_store_load;
  logic            w_dec_en;
  logic [NUM_DIGITS:0] w_borrow;
  logic            w_tick;
  logic            w_count_zero;
  logic            w_count_one;

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_clamp
    assign w_preset_clamped[i*4 +: 4] = clamp_bcd(bus.preset[i*4 +: 4]);
  end

  assign w_borrow[0] = 1'b1;

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    bcd_digit_down u_digit (
      .clock        (clock),
      .reset        (reset),
      .i_load       (w_load_digits),
      .i_load_val   (w_load_val[i*4 +: 4]),
      .i_dec_en     (w_dec_en),
      .i_borrow_in  (w_borrow[i]),
      .o_digit      (w_count[i*4 +: 4]),
      .o_borrow_out (w_borrow[i+1])
    );
  end

  // A borrow out of the top digit means every digit is 0.
  assign w_count_zero = w_borrow[NUM_DIGITS];
  assign w_count_one  = (w_count == 16'h0001);
  assign w_tick       = (r_presc == c_TICK_LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
      r_presc <= '0;
      r_store <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_presc <= w_presc_next;
      r_done  <= w_done_next;
      if (w_store_load) begin
        r_store <= w_preset_clamped;
      end
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_presc_next  = r_presc;
    w_done_next   = 1'b0;
    w_load_digits = 1'b0;
    w_load_val    = w_preset_clamped;
    w_store_load  = 1'b0;
    w_dec_en      = 1'b0;

    if (bus.load) begin
      w_load_digits = 1'b1;
      w_store_load  = 1'b1;
      w_presc_next  = '0;
      w_state_next  = IDLE;
    end else begin
      case (r_state)
        IDLE, PAUSE: begin
          if (!bus.stop && bus.start && !w_count_zero) begin
            w_state_next = RUN;
          end
        end
        RUN: begin
          if (bus.stop) begin
            w_state_next = PAUSE;
          end else if (!w_tick) begin
            w_presc_next = r_presc + PW'(1);
          end else begin
            w_presc_next = '0;
            if (w_count_one) begin
              w_done_next = 1'b1;
              // Reload from the store instead of landing on 0000; an empty store still expires.
              if (AUTO_RELOAD && (r_store != 16'h0000)) begin
                w_load_digits = 1'b1;
                w_load_val    = r_store;
              end else begin
                w_dec_en     = 1'b1;
                w_state_next = EXPIRED;
              end
            end else if (!w_count_zero) begin
              w_dec_en = 1'b1;
            end
          end
        end
        EXPIRED: begin
          w_state_next = EXPIRED;
        end
        default: begin
          w_state_next = IDLE;
        end
      endcase
    end
  end

  assign bus.digit0  = w_count[3:0];
  assign bus.digit1  = w_count[7:4];
  assign bus.digit2  = w_count[11:8];
  assign bus.digit3  = w_count[15:12];
  assign bus.running = (r_state == RUN);
  assign bus.zero    = w_count_zero;
  assign bus.done    = r_done;

endmodule

`default_nettype wire

// File: tb/tb_bcd4_down_timer.sv
// tb_bcd4_down_timer: four timer configurations driven in lockstep against an integer-count reference model.
`default_nettype none

module tb_bcd4_down_timer;

  localparam int NDUT = 4;
  localparam int TDS [NDUT] = '{1, 4, 1, 3};
  localparam int ARS [NDUT] = '{0, 0, 1, 1};
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_EXP = 3;

  logic        clk;
  logic        t_rst;
  logic        t_load;
  logic        t_start;
  logic        t_stop;
  logic [15:0] t_preset;

  logic [15:0] obs_dig  [NDUT];
  logic        obs_run  [NDUT];
  logic        obs_zero [NDUT];
  logic        obs_done [NDUT];

  int m_cnt   [NDUT];
  int m_store [NDUT];
  int m_tick  [NDUT];
  int m_mode  [NDUT];
  bit m_done  [NDUT];

  int n_chk;
  int n_err;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    bcd4_down_timer_if u_if ();
    assign u_if.load   = t_load;
    assign u_if.preset = t_preset;
    assign u_if.start  = t_start;
    assign u_if.stop   = t_stop;

    bcd4_down_timer #(.TICK_DIV(TDS[g]), .AUTO_RELOAD(ARS[g] != 0)) u_dut (
      .clock (clk),
      .reset (t_rst),
      .bus   (u_if)
    );

    assign obs_dig[g]  = {u_if.digit3, u_if.digit2, u_if.digit1, u_if.digit0};
    assign obs_run[g]  = u_if.running;
    assign obs_zero[g] = u_if.zero;
    assign obs_done[g] = u_if.done;
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  function automatic int preset_value(input logic [15:0] p);
    int s = 0;
    for (int i = 3; i >= 0; i--) begin
      int n = int'(p[i*4 +: 4]);
      if (n > 9) n = 9;
      s = s * 10 + n;
    end
    return s;
  endfunction

  task automatic model_step(input int k);
    m_done[k] = 1'b0;
    if (t_rst) begin
      m_cnt[k] = 0; m_store[k] = 0; m_tick[k] = 0; m_mode[k] = M_IDLE;
    end else if (t_load) begin
      m_cnt[k] = preset_value(t_preset);
      m_store[k] = m_cnt[k];
      m_tick[k] = 0;
      m_mode[k] = M_IDLE;
    end else if (m_mode[k] == M_RUN) begin
      if (t_stop) begin
        m_mode[k] = M_PAUSE;
      end else if (m_tick[k] < TDS[k] - 1) begin
        m_tick[k]++;
      end else begin
        m_tick[k] = 0;
        if (m_cnt[k] == 1) begin
          m_done[k] = 1'b1;
          if (ARS[k] != 0 && m_store[k] != 0) m_cnt[k] = m_store[k];
          else begin
            m_cnt[k] = 0;
            m_mode[k] = M_EXP;
          end
        end else if (m_cnt[k] > 0) begin
          m_cnt[k]--;
        end
      end
    end else if (m_mode[k] == M_IDLE || m_mode[k] == M_PAUSE) begin
      if (!t_stop && t_start && m_cnt[k] != 0) m_mode[k] = M_RUN;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    for (int k = 0; k < NDUT; k++) model_step(k);
    #1;
    for (int k = 0; k < NDUT; k++) begin
      chk($sformatf("d%0d.digits", k), 32'(obs_dig[k]), 32'(to_bcd(m_cnt[k])));
      chk($sformatf("d%0d.running", k), 32'(obs_run[k]), 32'(m_mode[k] == M_RUN));
      chk($sformatf("d%0d.zero", k), 32'(obs_zero[k]), 32'(m_cnt[k] == 0));
      chk($sformatf("d%0d.done", k), 32'(obs_done[k]), 32'(m_done[k]));
    end
  endtask

  task automatic go(input logic rst, input logic ld, input logic sa, input logic so,
                    input logic [15:0] pre, input int n);
    t_rst = rst; t_load = ld; t_start = sa; t_stop = so; t_preset = pre;
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    go(1, 0, 0, 0, 16'h0000, 2);
    chk("reset.zero", 32'(obs_zero[0]), 32'd1);
    chk("reset.digits", 32'(obs_dig[0]), 32'h0000);

    // Short countdown to expiry.
    go(0, 1, 0, 0, 16'h0003, 1);
    go(0, 0, 1, 0, 16'h0000, 1);
    go(0, 0, 0, 0, 16'h0000, 5);

    // Three-digit borrow chain.
    go(0, 1, 0, 0, 16'h1000, 1);
    go(0, 0, 1, 0, 16'h0000, 1);
    go(0, 0, 0, 0, 16'h0000, 1);
    chk("borrow.0999", 32'(obs_dig[0]), 32'h0999);
    go(0, 0, 0, 0, 16'h0000, 2);

    // Pause and resume, then stop+start together.
    go(0, 1, 0, 0, 16'h0510, 1);
    go(0, 0, 1, 0, 16'h0000, 1);
    go(0, 0, 0, 0, 16'h0000, 10);
    chk("pause.0500", 32'(obs_dig[0]), 32'h0500);
    go(0, 0, 0, 1, 16'h0000, 10);
    go(0, 0, 1, 0, 16'h0000, 1);
    go(0, 0, 0, 0, 16'h0000, 1);
    chk("resume.0499", 32'(obs_dig[0]), 32'h0499);
    go(0, 0, 1, 1, 16'h0000, 3);
    go(0, 0, 1, 0, 16'h0000, 2);

    // Clamp and zero-count start.
    go(0, 1, 0, 0, 16'h00A5, 1);
    chk("clamp.0095", 32'(obs_dig[0]), 32'h0095);
    go(0, 1, 0, 0, 16'hFFFF, 1);
    chk("clamp.9999", 32'(obs_dig[1]), 32'h9999);
    go(0, 1, 0, 0, 16'h0000, 1);
    go(0, 0, 1, 0, 16'h0000, 3);

    // Prescaled countdown and auto-reload.
    go(0, 1, 0, 0, 16'h0002, 1);
    go(0, 0, 1, 0, 16'h0000, 1);
    go(0, 0, 0, 0, 16'h0000, 12);

    // Reset mid-run; load coinciding with expiry.
    go(0, 1, 0, 0, 16'h0005, 1);
    go(0, 0, 1, 0, 16'h0000, 3);
    go(1, 0, 0, 0, 16'h0000, 1);
    go(0, 0, 0, 0, 16'h0000, 2);
    go(0, 1, 0, 0, 16'h0002, 1);
    go(0, 0, 1, 0, 16'h0000, 2);
    go(0, 1, 0, 0, 16'h0007, 1);
    go(0, 0, 0, 0, 16'h0000, 2);

    for (int i = 0; i < 3000; i++) begin
      int r = int'($urandom_range(0, 99));
      logic [15:0] pre;
      if ($urandom_range(0, 1) == 0) pre = {12'h000, 4'($urandom_range(0, 15))};
      else pre = 16'($urandom());
      go(r == 0, (r >= 1 && r <= 4), ($urandom_range(0, 9) < 3), ($urandom_range(0, 9) == 0), pre, 1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
